// File: rtl/execute_pkg.sv
// Shared core definitions for the execute stage: ALU operation codes, datapath
// defaults and the mul/div sequencer states.
package execute_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring-divide step
// per cycle on operand magnitudes, sign applied when the result is read out.
module ex_muldiv
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   state;
    logic [4:0]  cnt;
    alu_op_e     op_q;
    logic [31:0] dsor_q, hi_q, lo_q, special_res_q;
    logic        neg_q, neg_r_q, special_q;

    logic        a_neg, b_neg, is_div, is_rem, div_ovf;
    logic [31:0] a_mag, b_mag, hi_nxt, lo_nxt, quo, rem;
    logic [32:0] sum, tmp, diff;
    logic [63:0] prod;

    function automatic logic [63:0] apply_sign64(logic [63:0] v, logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign32(logic [31:0] v, logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        a_neg   = a[31] && (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        b_neg   = b[31] && (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
        a_mag   = apply_sign32(a, a_neg);
        b_mag   = apply_sign32(b, b_neg);
        is_div  = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        is_rem  = op inside {ALU_REM, ALU_REMU};
        div_ovf = (op inside {ALU_DIV, ALU_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end

    // hi:lo is the product accumulator for multiplies, remainder:quotient for divides
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsor_q} : 33'd0);
        tmp  = {hi_q, lo_q[31]};
        diff = tmp - {1'b0, dsor_q};
        if (op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
            if (!diff[32]) begin
                hi_nxt = diff[31:0];
                lo_nxt = {lo_q[30:0], 1'b1};
            end else begin
                hi_nxt = tmp[31:0];
                lo_nxt = {lo_q[30:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo_q[31:1]};
        end
    end

    always_comb begin
        prod = apply_sign64({hi_q, lo_q}, neg_q);
        quo  = apply_sign32(lo_q, neg_q);
        rem  = apply_sign32(hi_q, neg_r_q);
        case (op_q)
            ALU_MUL:                        result = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[63:32];
            ALU_DIV, ALU_DIVU:              result = quo;
            default:                        result = rem;
        endcase
        if (special_q) result = special_res_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    cnt     <= 5'd0;
                    op_q    <= op;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
                    hi_q    <= 32'd0;
                    dsor_q  <= is_div ? b_mag : a_mag;
                    lo_q    <= is_div ? a_mag : b_mag;
                    // Divide-by-zero and signed overflow have fixed answers; skip the iteration
                    if (is_div && (b == 32'd0 || div_ovf)) begin
                        special_q     <= 1'b1;
                        special_res_q <= (b == 32'd0) ? (is_rem ? a : 32'hFFFF_FFFF)
                                                      : (is_rem ? 32'd0 : 32'h8000_0000);
                        state         <= MD_DONE;
                        done          <= 1'b1;
                    end else begin
                        special_q <= 1'b0;
                        state     <= MD_BUSY;
                        busy      <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= MD_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU feeding the EX/MEM register. Defining
// EXECUTE_MULDIV_EN adds the iterative mul/div unit and the ex_stall hold.
module execute
    import execute_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_EX_valid,
    input  logic [XLEN-1:0] ID_EX_PC,
    input  logic [XLEN-1:0] ID_EX_Instr,
    input  logic [XLEN-1:0] ID_EX_rdata1,
    input  logic [XLEN-1:0] ID_EX_rdata2,
    input  logic [XLEN-1:0] ID_EX_Imm,
    input  logic            ID_EX_ALUSrc,
    input  logic [4:0]      ID_EX_ALUOp,
    input  logic [4:0]      ID_EX_rd,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_RegWrite,
    input  logic [1:0]      ID_EX_Mem2Reg,
    output logic            ex_stall,
    output logic [XLEN-1:0] EX_MEM_PC,
    output logic [XLEN-1:0] EX_MEM_Instr,
    output logic [XLEN-1:0] EX_MEM_ALU_Result,
    output logic [XLEN-1:0] EX_MEM_rdata2,
    output logic [4:0]      EX_MEM_rd,
    output logic            EX_MEM_MemWrite,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_RegWrite,
    output logic [1:0]      EX_MEM_Mem2Reg
);

    alu_op_e                op;
    logic signed [XLEN-1:0] op_a, op_b;
    logic        [XLEN-1:0] alu_result, md_result;
    logic                   md_start, md_busy, md_done, bubble;

    assign op   = alu_op_e'(ID_EX_ALUOp);
    assign op_a = ID_EX_rdata1;
    assign op_b = ID_EX_ALUSrc ? ID_EX_Imm : ID_EX_rdata2;

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLL:   alu_result = op_a << op_b[4:0];
            ALU_SRL:   alu_result = $unsigned(op_a) >> op_b[4:0];
            ALU_SRA:   alu_result = op_a >>> op_b[4:0];
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, $unsigned(op_a) < $unsigned(op_b)};
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

`ifdef EXECUTE_MULDIV_EN
    assign md_start = ID_EX_valid && is_muldiv(op) && !md_busy && !md_done;

    ex_muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op),
        .a      (ID_EX_rdata1),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign md_start  = 1'b0;
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    assign ex_stall = md_start | md_busy;
    assign bubble   = ex_stall || !ID_EX_valid;

    // EX/MEM register boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            EX_MEM_PC         <= '0;
            EX_MEM_Instr      <= NOP_INSTR;
            EX_MEM_ALU_Result <= '0;
            EX_MEM_rdata2     <= '0;
            EX_MEM_rd         <= 5'd0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_Mem2Reg    <= 2'd0;
        end else begin
            EX_MEM_PC         <= ID_EX_PC;
            EX_MEM_rdata2     <= ID_EX_rdata2;
            EX_MEM_Instr      <= bubble ? NOP_INSTR : ID_EX_Instr;
            EX_MEM_ALU_Result <= bubble ? '0 : (md_done ? md_result : alu_result);
            EX_MEM_rd         <= bubble ? 5'd0 : ID_EX_rd;
            EX_MEM_MemWrite   <= !bubble && ID_EX_MemWrite;
            EX_MEM_MemRead    <= !bubble && ID_EX_MemRead;
            EX_MEM_RegWrite   <= !bubble && ID_EX_RegWrite;
            EX_MEM_Mem2Reg    <= bubble ? 2'd0 : ID_EX_Mem2Reg;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed vector table, randomized ALU and
// mul/div traffic against an arithmetic reference, reset corner sequences.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_EX_valid;
    logic [31:0] ID_EX_PC, ID_EX_Instr, ID_EX_rdata1, ID_EX_rdata2, ID_EX_Imm;
    logic        ID_EX_ALUSrc;
    logic [4:0]  ID_EX_ALUOp, ID_EX_rd;
    logic        ID_EX_MemWrite, ID_EX_MemRead, ID_EX_RegWrite;
    logic [1:0]  ID_EX_Mem2Reg;
    logic        ex_stall;
    logic [31:0] EX_MEM_PC, EX_MEM_Instr, EX_MEM_ALU_Result, EX_MEM_rdata2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_Mem2Reg;

    int passed = 0;
    int total  = 0;

    execute dut (
        .clk(clk), .rst(rst), .ID_EX_valid(ID_EX_valid), .ID_EX_PC(ID_EX_PC),
        .ID_EX_Instr(ID_EX_Instr), .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2),
        .ID_EX_Imm(ID_EX_Imm), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_rd(ID_EX_rd), .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Mem2Reg(ID_EX_Mem2Reg), .ex_stall(ex_stall),
        .EX_MEM_PC(EX_MEM_PC), .EX_MEM_Instr(EX_MEM_Instr), .EX_MEM_ALU_Result(EX_MEM_ALU_Result),
        .EX_MEM_rdata2(EX_MEM_rdata2), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_Mem2Reg(EX_MEM_Mem2Reg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        src;
        logic        valid;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    // Reference arithmetic, written straight from the operation definitions
    function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return sa >>> b[4:0];
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_PASSB:  return b;
            ALU_MUL:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            ALU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                        else return sa / sb;
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    if (b == 0) return a;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                        else return sa % sb;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic valid);
        ID_EX_valid    = valid;
        ID_EX_ALUOp    = op;
        ID_EX_rdata1   = a;
        ID_EX_ALUSrc   = src;
        ID_EX_Imm      = src ? b : 32'h0000_DEAD;
        ID_EX_rdata2   = src ? 32'h5A5A_1234 : b;
        ID_EX_PC       = ID_EX_PC + 32'd4;
        ID_EX_Instr    = 32'h00A5_0533 ^ {27'd0, op};
        ID_EX_rd       = 5'd9;
        ID_EX_RegWrite = 1'b1;
        ID_EX_MemWrite = 1'b0;
        ID_EX_MemRead  = 1'b0;
        ID_EX_Mem2Reg  = 2'd1;
    endtask

    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit chk_lat);
        int stalls = 0;
        int edges  = 0;
        bit got    = 0;
        drive(op, a, b, 1'b0, 1'b1);
        #1;
        while (edges < 100 && !got) begin
            if (ex_stall) stalls++;
            @(posedge clk); #1;
            edges++;
            if (EX_MEM_RegWrite) got = 1;
        end
        ID_EX_valid = 1'b0;
        chk("md_completes", {31'd0, got}, 32'd1);
        chk($sformatf("md_op%0d_result a=%h b=%h", op, a, b), EX_MEM_ALU_Result, ref_op(op, a, b));
        if (chk_lat) begin
            chk("md_latency_edges", edges, 34);
            chk("md_stall_cycles", stalls, 33);
        end
    endtask

    initial begin
        int          stall_seen;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        logic        rsrc;

        vecs[0]  = '{ALU_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000};
        vecs[1]  = '{ALU_SUB,   32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{ALU_AND,   32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b1, 32'h0000_F000};
        vecs[3]  = '{ALU_OR,    32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b1, 32'h0000_FFF0};
        vecs[4]  = '{ALU_XOR,   32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b1, 32'h0000_0FF0};
        vecs[5]  = '{ALU_SLL,   32'h0000_0001, 32'h0000_0021, 1'b0, 1'b1, 32'h0000_0002};
        vecs[6]  = '{ALU_SRL,   32'h8000_0000, 32'h0000_0004, 1'b0, 1'b1, 32'h0800_0000};
        vecs[7]  = '{ALU_SRA,   32'h8000_0000, 32'h0000_0024, 1'b0, 1'b1, 32'hF800_0000};
        vecs[8]  = '{ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001};
        vecs[9]  = '{ALU_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001};
        vecs[10] = '{ALU_PASSB, 32'h1111_1111, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
        vecs[11] = '{ALU_ADD,   32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_0000};

        ID_EX_PC = 32'h0000_1000;
        drive(ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_alu", EX_MEM_ALU_Result, 32'd0);
        chk("reset_instr", EX_MEM_Instr, 32'h0000_0013);
        chk("reset_pc", EX_MEM_PC, 32'd0);
        chk("reset_ctrl", {24'd0, EX_MEM_rd, EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead},
            32'd0);
        chk("reset_stall", {31'd0, ex_stall}, 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].valid);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, ex_stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_result", i), EX_MEM_ALU_Result, vecs[i].exp);
            chk($sformatf("vec%0d_regwrite", i), {31'd0, EX_MEM_RegWrite}, {31'd0, vecs[i].valid});
            chk($sformatf("vec%0d_instr", i), EX_MEM_Instr,
                vecs[i].valid ? ID_EX_Instr : 32'h0000_0013);
            chk($sformatf("vec%0d_rdata2", i), EX_MEM_rdata2, ID_EX_rdata2);
            chk($sformatf("vec%0d_rd", i), {27'd0, EX_MEM_rd}, vecs[i].valid ? 32'd9 : 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            rop  = 5'($urandom_range(0, 10));
            ra   = $urandom;
            rb   = $urandom;
            rsrc = 1'($urandom_range(0, 1));
            drive(rop, ra, rb, rsrc, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("rand_op%0d a=%h b=%h", rop, ra, rb), EX_MEM_ALU_Result, ref_op(rop, ra, rb));
        end

`ifdef EXECUTE_MULDIV_EN
        run_md(ALU_MULH, 32'hFFFF_FFFE, 32'd3, 1'b1);
        run_md(ALU_MUL,  32'hFFFF_FFFE, 32'd3, 1'b1);
        run_md(ALU_DIV,  32'd7, 32'd0, 1'b0);
        run_md(ALU_REM,  32'd7, 32'd0, 1'b0);
        run_md(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md(ALU_DIVU, 32'hFFFF_FFF0, 32'd7, 1'b1);
        for (int n = 0; n < 16; n++) begin
            rop = 5'($urandom_range(ALU_MUL, ALU_REMU));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_md(rop, ra, rb, 1'b0);
        end

        // Reset while the divider is mid-iteration
        drive(ALU_DIV, 32'd1000, 32'd7, 1'b0, 1'b1);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(ALU_ADD, 32'd5, 32'd6, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("midbusy_reset_alu", EX_MEM_ALU_Result, 32'd0);
        chk("midbusy_reset_instr", EX_MEM_Instr, 32'h0000_0013);
        chk("midbusy_reset_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd0);
        chk("midbusy_reset_stall", {31'd0, ex_stall}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_add", EX_MEM_ALU_Result, 32'd11);
        ID_EX_valid = 1'b0;
        stall_seen  = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (EX_MEM_RegWrite || ex_stall) stall_seen++;
        end
        chk("abandoned_no_result", stall_seen, 0);
`else
        for (int o = ALU_MUL; o <= ALU_REMU; o++) begin
            drive(5'(o), 32'd7, 32'd3, 1'b0, 1'b1);
            #1;
            chk($sformatf("nomd_op%0d_stall", o), {31'd0, ex_stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("nomd_op%0d_result", o), EX_MEM_ALU_Result, 32'd0);
            chk($sformatf("nomd_op%0d_regwrite", o), {31'd0, EX_MEM_RegWrite}, 32'd1);
        end
        drive(ALU_ADD, 32'd5, 32'd6, 1'b0, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_again_alu", EX_MEM_ALU_Result, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_add", EX_MEM_ALU_Result, 32'd11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction word for bubbles.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port ID_EX_valid  in  1  issued instruction present.
REQ-006 SHALL have port ID_EX_PC / ID_EX_Instr  in  32 each  PC and instruction word.
REQ-007 SHALL have port ID_EX_rdata1 / ID_EX_rdata2 / ID_EX_Imm  in  32 each  operands and immediate.
REQ-008 SHALL have port ID_EX_ALUSrc  in  1  operand B select: 1=Imm, 0=rdata2.
REQ-009 SHALL have port ID_EX_ALUOp  in  5  operation code from the shared package.
REQ-010 SHALL have port ID_EX_rd  in  5, and ID_EX_MemWrite, ID_EX_MemRead, ID_EX_RegWrite  in  1 each, and ID_EX_Mem2Reg  in  2: control passed downstream.
REQ-011 SHALL have port ex_stall  out  1  upstream hold request.
REQ-012 SHALL have registered ports EX_MEM_PC, EX_MEM_Instr, EX_MEM_ALU_Result, EX_MEM_rdata2 (out, 32 each), EX_MEM_rd (out, 5), EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_RegWrite (out, 1 each), EX_MEM_Mem2Reg (out, 2).

Function
REQ-013 Single-cycle ops (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU PASSB) SHALL register their result in EX_MEM_ALU_Result one edge after issue, with ex_stall low.
REQ-014 Shifts SHALL use B[4:0]; SLT is signed and SLTU unsigned, both giving 0/1; ADD/SUB SHALL wrap modulo 2^32.
REQ-015 EX_MEM_rdata2 SHALL carry ID_EX_rdata2 unmodified; the other control/PC/Instr fields SHALL pass through alongside the result.
REQ-016 ID_EX_valid=0 SHALL load a bubble: RegWrite, MemWrite and MemRead=0, rd=0, Mem2Reg=0, ALU_Result=0, Instr=NOP_INSTR.
REQ-017 Mul/div FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 IDLE to BUSY on a valid mul/div op: ex_stall SHALL assert combinationally in that cycle, latch operands, clear the 5-bit counter, and load a bubble into EX_MEM.
REQ-019 BUSY SHALL perform one shift-add (MUL*) or restoring-divide (DIV*/REM*) step per cycle on magnitudes, hold ex_stall high, load a bubble into EX_MEM, and go to DONE after step 31 (32 cycles).
REQ-020 DONE SHALL drop ex_stall, load the sign-corrected result and the held ID_EX fields into EX_MEM, then return to IDLE.
REQ-021 Total mul/div latency SHALL be 34 edges from issue to EX_MEM valid, with 33 ex_stall-high cycles.
REQ-022 Upstream SHALL hold all ID_EX inputs stable while ex_stall=1; the block SHALL use only the operands latched in REQ-018.
REQ-023 MUL SHALL return the low 32 bits; MULH/MULHSU/MULHU SHALL return the high 32 bits with ss/su/uu signedness.
REQ-024 Divide by zero SHALL give quotient 32'hFFFFFFFF and remainder = dividend; signed 32'h80000000 / -1 SHALL give quotient 32'h80000000 and remainder 0, without iterating (straight to DONE).

Reset
REQ-025 rst=0 at posedge SHALL force FSM to IDLE, counter to 0, ex_stall to 0 and all EX_MEM outputs to 0 except EX_MEM_Instr=NOP_INSTR.
REQ-026 Reset mid-BUSY SHALL abandon the operation with no result emitted.

Configuration
REQ-027 With macro EXECUTE_MULDIV_EN defined, REQ-017..REQ-024 SHALL apply.
REQ-028 With EXECUTE_MULDIV_EN undefined, no FSM SHALL exist, ex_stall SHALL be tied 0, and mul/div opcodes SHALL produce result 0 in one cycle.

Structure
REQ-029 The ALUOp encodings, XLEN and NOP_INSTR defaults SHALL live in the shared core package.
REQ-030 The iterative unit SHALL be sub-module ex_muldiv (start/busy/done handshake), instantiated only under EXECUTE_MULDIV_EN.

Verification
REQ-031 ADD rdata1=32'h7FFFFFFF, Imm=1, ALUSrc=1 -> next edge ALU_Result=32'h80000000, stall 0.
REQ-032 SRA A=32'h80000000, B=32'h00000024 -> 32'hF8000000; SLTU A=1, B=32'hFFFFFFFF -> 1.
REQ-033 MULH A=-2, B=3 -> 33 stall cycles of bubbles, then ALU_Result=32'hFFFFFFFF, with MUL yielding 32'hFFFFFFFA.
REQ-034 DIV 7/0 -> 32'hFFFFFFFF; REM 7/0 -> 7; DIV 32'h80000000/-1 -> 32'h80000000.
REQ-035 rst=0 at BUSY cycle 10 -> outputs at reset values next edge, stall 0, and the next ADD completes normally.
REQ-036 valid=0 with RegWrite=1 -> EX_MEM_RegWrite=0, Instr=32'h00000013.
